// File: rtl/instr_mem_loader_pkg.sv
// Shared types for the instruction memory loader.
// State encoding and word geometry.
package instr_mem_loader_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_CNT_HI,
    ST_CNT_LO,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and memory write port of the loader.
// master = loader side, slave = host source / memory side.
interface instr_mem_loader_if;

  logic        BYTE_VALID;
  logic [7:0]  BYTE_DATA;
  logic        BYTE_READY;
  logic [31:0] A;
  logic [31:0] WD;
  logic        WE;

  modport master (
    input  BYTE_VALID,
    input  BYTE_DATA,
    output BYTE_READY,
    output A,
    output WD,
    output WE
  );

  modport slave (
    output BYTE_VALID,
    output BYTE_DATA,
    input  BYTE_READY,
    input  A,
    input  WD,
    input  WE
  );

endinterface

// File: rtl/instr_mem_loader_byte_word_assembler.sv
// Packs MSB-first bytes into a 32-bit word.
// word_o already includes the byte being accepted.
module byte_word_assembler
  import instr_mem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_complete_o
);

  logic [23:0] sr_q;
  logic [1:0]  idx_q;

  assign word_o = {sr_q, byte_i};
  assign word_complete_o =
    en_i && (idx_q == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else if (clr_i) begin
      idx_q <= '0;
    end else if (en_i) begin
      sr_q  <= {sr_q[15:0], byte_i};
      idx_q <= idx_q + 2'd1;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Length-prefixed byte-stream loader for instruction memory.
// Holds the CPU in reset until the whole image is written.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic                START,
  instr_mem_loader_if.master  bus,
  output logic                CPU_HOLD,
  output logic                DONE,
  output logic                ERROR
);

  state_e      state_q;
  logic [15:0] count_q;
  logic [15:0] word_idx_q;
  logic [31:0] a_q;
  logic [31:0] wd_q;

  logic        xfer;
  logic [15:0] count_d;
  logic [31:0] word;
  logic        word_done;

  assign xfer    = bus.BYTE_VALID && bus.BYTE_READY;
  assign count_d = {count_q[15:8], bus.BYTE_DATA};

  byte_word_assembler u_asm (
    .clk_i           (CLOCK),
    .rst_i           (RESET),
    .clr_i           (state_q != ST_DATA),
    .en_i            (xfer && state_q == ST_DATA),
    .byte_i          (bus.BYTE_DATA),
    .word_o          (word),
    .word_complete_o (word_done)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q    <= ST_CNT_HI;
      count_q    <= '0;
      word_idx_q <= '0;
      a_q        <= BASE_ADDR;
      wd_q       <= '0;
    end else begin
      unique case (state_q)
        ST_CNT_HI: if (xfer) begin
          count_q <= {bus.BYTE_DATA, 8'h00};
          state_q <= ST_CNT_LO;
        end
        ST_CNT_LO: if (xfer) begin
          count_q    <= count_d;
          word_idx_q <= '0;
          if (count_d == 16'd0)
            state_q <= ST_DONE;
          else if (32'(count_d) > MAX_WORDS)
            state_q <= ST_ERROR;
          else
            state_q <= ST_DATA;
        end
        // A/WD are loaded here so they are stable for the whole WRITE cycle
        ST_DATA: if (word_done) begin
          a_q     <= BASE_ADDR + {14'b0, word_idx_q, 2'b00};
          wd_q    <= word;
          state_q <= ST_WRITE;
        end
        ST_WRITE: begin
          if (word_idx_q + 16'd1 == count_q) begin
            state_q <= ST_DONE;
          end else begin
            word_idx_q <= word_idx_q + 16'd1;
            state_q    <= ST_DATA;
          end
        end
        ST_DONE, ST_ERROR: if (START)
          state_q <= ST_CNT_HI;
        default: state_q <= ST_CNT_HI;
      endcase
    end
  end

  assign bus.BYTE_READY = state_q inside
    {ST_CNT_HI, ST_CNT_LO, ST_DATA};
  assign bus.WE = (state_q == ST_WRITE);
  assign bus.A  = a_q;
  assign bus.WD = wd_q;
  assign DONE     = (state_q == ST_DONE);
  assign ERROR    = (state_q == ST_ERROR);
  assign CPU_HOLD = (state_q != ST_DONE);

endmodule
